countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Down-counting counterpart of the elapsed-time up-counter.
- Loads a duration in ticks and decrements once per accepted time-base tick until it reaches zero.
- Flags the final 4 s and final 2 s, then raises a registered expiry pulse and a done level.
- Sits between the game/lab control FSM, which loads, starts and holds it, and the display/LED logic, which reads the remaining time and the flags.

Parameters:
- WIDTH, 16: width of the duration and count registers.
- TICKS_PER_SEC, 8: number of `tick` pulses per second; sets the warning thresholds.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- D  in  WIDTH  duration to load, in ticks.
- load  in  1  capture `D` into the counter.
- start  in  1  begin counting a loaded, non-zero value.
- hold  in  1  level-sensitive; while high, ticks are ignored.
- tick  in  1  one-cycle time-base strobe.
- time_left  out  WIDTH  remaining ticks.
- running  out  1  high in the RUN or HOLD state.
- warn_4  out  1  high when running, `time_left` != 0, and `time_left` <= 4*TICKS_PER_SEC.
- warn_2  out  1  high when running, `time_left` != 0, and `time_left` <= 2*TICKS_PER_SEC.
- expired  out  1  one-cycle pulse on reaching zero.
- done  out  1  high in the DONE state.

Behaviour:
- All outputs are registered, or decoded from registered state only; no combinational input-to-output path.
- Reset (reset=0 at an edge):
  - state=IDLE, `time_left`=0.
  - `running`, `warn_4`, `warn_2`, `expired`, `done` all 0.
  - Reset overrides every other input, including a reset mid-RUN.
- States: IDLE, ARMED, RUN, HOLD, DONE.
- Priority each edge: reset > load > start > hold > tick.
- `load` (any state):
  - `time_left` <= `D`.
  - Next state is ARMED if `D` != 0, IDLE if `D` == 0.
  - Aborts any RUN, HOLD or DONE in progress; no `expired` pulse is generated.
- `start`:
  - ARMED -> RUN (or HOLD if `hold`=1 in the same cycle).
  - Ignored in IDLE, RUN, HOLD and DONE.
  - Ignored in the same cycle as `load`.
- RUN:
  - `hold`=1 -> HOLD on the next edge.
  - Otherwise `tick`=1 -> `time_left` <= `time_left` - 1 on the same edge.
  - If `time_left` was 1, the next state is DONE and `expired`=1 for exactly the following cycle.
- HOLD:
  - `tick` is ignored and `time_left` is frozen.
  - `hold`=0 -> RUN on the next edge.
  - A `tick` on the cycle `hold` falls is still ignored.
- DONE:
  - `time_left`=0, `done`=1.
  - Remains until `load` or reset.
  - `tick`, `start` and `hold` are ignored.
- Latency: a `tick` sampled at edge N shows in `time_left` after edge N; `expired` and `done` assert after that same edge.
- No wrap-around: `time_left` never decrements below 0 and never decrements outside RUN.
- Warnings:
  - Thresholds are computed at elaboration, WIDTH bits wide.
  - If a threshold is >= 2^WIDTH, the corresponding flag is high whenever running with a non-zero count.
  - `warn_2` implies `warn_4`.
- `tick` held high continuously decrements once per clock; this is legal.

Test Plan:
- Reset: hold reset=0 for 2 cycles with `load`=1, `D`=40 -> `time_left`=0, state IDLE, all flags 0.
- Full countdown: `load` `D`=40, `start`, then 40 ticks (TICKS_PER_SEC=8) ->
  - `warn_4` rises after the 8th tick (`time_left`=32).
  - `warn_2` rises after the 24th tick (`time_left`=16).
  - After the 40th tick: `time_left`=0, `expired` high exactly 1 cycle, `done` stays 1, `running`=0.
- Hold: during RUN at `time_left`=20, assert `hold` for 10 cycles with `tick` every cycle -> `time_left` stays 20; after release, the first accepted tick gives 19.
- Reload mid-run: at `time_left`=5, `load` `D`=12 together with `tick` -> `time_left`=12, state ARMED, no `expired` pulse; subsequent ticks ignored until `start`.
- Zero and illegal start: `load` `D`=0, then `start` and ticks -> state IDLE, `time_left`=0, no `expired`, `done`=0; `start` in DONE is ignored.
- Reset mid-run: at `time_left`=3 in RUN, reset=0 with `tick`=1 -> after the edge, `time_left`=0, IDLE, no `expired` pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/hold control, 4 s / 2 s warnings, expiry pulse and done level
module countdown_timer #(
    parameter int WIDTH         = 16,
    parameter int TICKS_PER_SEC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    input  logic             start,
    input  logic             hold,
    input  logic             tick,
    output logic [WIDTH-1:0] time_left,
    output logic             running,
    output logic             warn_4,
    output logic             warn_2,
    output logic             expired,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, DONE} state_t;

    localparam longint LIM = 64'(1) << WIDTH;
    localparam longint T4  = 64'(4) * TICKS_PER_SEC;
    localparam longint T2  = 64'(2) * TICKS_PER_SEC;
    localparam logic [WIDTH-1:0] TH4 = (T4 >= LIM) ? {WIDTH{1'b1}} : T4[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TH2 = (T2 >= LIM) ? {WIDTH{1'b1}} : T2[WIDTH-1:0];

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             expired_n;

    // state, count and expiry pulse registers; active-low synchronous reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            time_left <= '0;
            expired   <= 1'b0;
        end else begin
            state     <= state_n;
            time_left <= count_n;
            expired   <= expired_n;
        end
    end

    // next state: load > start > hold > tick
    always_comb begin
        state_n   = state;
        count_n   = time_left;
        expired_n = 1'b0;
        if (load) begin
            count_n = D;
            state_n = (D != '0) ? ARMED : IDLE;
        end else begin
            case (state)
                ARMED: if (start) state_n = hold ? HOLD : RUN;
                RUN: begin
                    if (hold) begin
                        state_n = HOLD;
                    end else if (tick && time_left != '0) begin
                        count_n = time_left - 1'b1;
                        if (time_left == WIDTH'(1)) begin
                            state_n   = DONE;
                            expired_n = 1'b1;
                        end
                    end
                end
                HOLD: if (!hold) state_n = RUN;
                default: ;
            endcase
        end
    end

    assign running = (state == RUN) || (state == HOLD);
    assign done    = (state == DONE);
    assign warn_4  = running && (time_left != '0) && (time_left <= TH4);
    assign warn_2  = running && (time_left != '0) && (time_left <= TH2);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus against a behavioural countdown model
module tb_countdown_timer;
    localparam int W   = 16;
    localparam int TPS = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] D = '0;
    logic         load = 1'b0, start = 1'b0, hold = 1'b0, tick = 1'b0;
    logic [W-1:0] time_left;
    logic         running, warn_4, warn_2, expired, done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    int m_left = 0;
    bit m_armed = 0, m_run = 0, m_pause = 0, m_done = 0, m_exp = 0;

    countdown_timer #(.WIDTH(W), .TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .reset(reset), .D(D), .load(load), .start(start), .hold(hold), .tick(tick),
        .time_left(time_left), .running(running), .warn_4(warn_4), .warn_2(warn_2),
        .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: armed / counting / paused / finished flags plus remaining ticks
    always @(posedge clk) begin
        m_exp = 0;
        if (!reset) begin
            m_left = 0; m_armed = 0; m_run = 0; m_pause = 0; m_done = 0;
        end else if (load) begin
            m_left = int'(D); m_armed = (D != 0); m_run = 0; m_pause = 0; m_done = 0;
        end else if (m_armed && start) begin
            m_armed = 0; m_run = 1; m_pause = hold;
        end else if (m_run && m_pause) begin
            m_pause = hold;
        end else if (m_run && hold) begin
            m_pause = 1;
        end else if (m_run && tick && m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 0; m_done = 1; m_exp = 1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("time_left", int'(time_left), m_left);
            check("running", int'(running), int'(m_run));
            check("warn_4", int'(warn_4), int'(m_run && m_left != 0 && m_left <= 4 * TPS));
            check("warn_2", int'(warn_2), int'(m_run && m_left != 0 && m_left <= 2 * TPS));
            check("expired", int'(expired), int'(m_exp));
            check("done", int'(done), int'(m_done));
        end
    end

    task automatic step(input logic rs, input logic ld, input logic st, input logic hd, input logic tk, input int d);
        reset = rs; load = ld; start = st; hold = hd; tick = tk; D = W'(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        step(0, 1, 0, 0, 0, 40);
        step(0, 1, 0, 0, 0, 40);
        check("rst_time_left", int'(time_left), 0);
        check("rst_flags", int'({running, warn_4, warn_2, expired, done}), 0);
        chk_en = 1;

        step(1, 1, 0, 0, 0, 40);
        step(1, 0, 1, 0, 0, 0);
        check("run_started", int'(running), 1);
        for (int i = 1; i <= 40; i++) begin
            step(1, 0, 0, 0, 1, 0);
            if (i == 7) check("warn4_before", int'(warn_4), 0);
            if (i == 8) begin
                check("warn4_rise", int'(warn_4), 1);
                check("left_32", int'(time_left), 32);
            end
            if (i == 23) check("warn2_before", int'(warn_2), 0);
            if (i == 24) begin
                check("warn2_rise", int'(warn_2), 1);
                check("left_16", int'(time_left), 16);
            end
        end
        check("expire_pulse", int'(expired), 1);
        check("expire_done", int'({done, running}), 2);
        check("expire_left", int'(time_left), 0);
        step(1, 0, 0, 0, 1, 0);
        check("pulse_one_cycle", int'(expired), 0);
        step(1, 0, 1, 0, 1, 0);
        check("start_in_done", int'({done, running}), 2);

        step(1, 1, 0, 0, 0, 40);
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 0);
        check("pre_hold", int'(time_left), 20);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 0);
        check("hold_frozen", int'(time_left), 20);
        step(1, 0, 0, 0, 1, 0);
        check("release_tick_ignored", int'(time_left), 20);
        step(1, 0, 0, 0, 1, 0);
        check("after_hold", int'(time_left), 19);

        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 1, 0);
        check("pre_reload", int'(time_left), 5);
        step(1, 1, 0, 0, 1, 12);
        check("reload_left", int'(time_left), 12);
        check("reload_flags", int'({running, expired, done}), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        check("armed_ignores_tick", int'(time_left), 12);

        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        check("zero_left", int'(time_left), 0);
        check("zero_flags", int'({running, expired, done}), 0);

        step(1, 1, 0, 0, 0, 4);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        check("pre_reset", int'(time_left), 3);
        step(0, 0, 0, 0, 1, 0);
        check("midrun_reset", int'({time_left, running, expired, done}), 0);

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50)));

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
